// File: rtl/hsst2ad_pkg.sv
// hsst2ad_pkg
//   Shared definitions for the hsst2ad frame unpacker: sync header bytes,
//   the byte-level FSM state type and the sample record carried through
//   the skid buffer.
//   No ports (package).

package hsst2ad_pkg;

  localparam int DATA_W = 8;

  localparam logic [DATA_W-1:0] SYNC0 = 8'hEB;
  localparam logic [DATA_W-1:0] SYNC1 = 8'h90;

  typedef enum logic [2:0] {
    HUNT0,
    HUNT1,
    LEN,
    HI,
    LO,
    CSUM
  } state_t;

  typedef struct packed {
    logic        last;
    logic [15:0] data;
  } sample_t;

endpackage

// File: rtl/hsst2ad_skid2.sv
// hsst2ad_skid2
//   Two-entry valid/ready buffer for {last, data} samples. Entries leave in
//   push order. The occupancy is exported so the producer can gate reads
//   that would otherwise overrun the buffer.
// Ports
//   clk          in   clock
//   tb_rst       in   async reset, active-high
//   push_i       in   write a new entry this cycle
//   pushData_i   in   entry to write
//   outReady_i   in   downstream accept
//   outValid_o   out  head entry is valid
//   outData_o    out  head entry
//   occ_o        out  number of stored entries (0..2)

import hsst2ad_pkg::*;

module hsst2ad_skid2 (
  input  logic       clk,
  input  logic       tb_rst,
  input  logic       push_i,
  input  sample_t    pushData_i,
  input  logic       outReady_i,
  output logic       outValid_o,
  output sample_t    outData_o,
  output logic [1:0] occ_o
);

  sample_t    mem_q [2];
  logic       wrPtr_q;
  logic       rdPtr_q;
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic       pop;
  logic       pushOk;

  assign pop        = (count_q != 2'd0) && outReady_i;
  // A push into a full buffer is still legal when the head leaves in the
  // same cycle, because the pop frees the slot being written.
  assign pushOk     = push_i && ((count_q != 2'd2) || pop);
  assign outValid_o = (count_q != 2'd0);
  assign outData_o  = mem_q[rdPtr_q];
  assign occ_o      = count_q;

  always_comb begin
    count_d = count_q;
    case ({pushOk, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wrPtr_q  <= 1'b0;
      rdPtr_q  <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (pushOk) begin
        mem_q[wrPtr_q] <= pushData_i;
        wrPtr_q        <= ~wrPtr_q;
      end
      if (pop) begin
        rdPtr_q <= ~rdPtr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/hsst2ad_frame_unpack.sv
// hsst2ad_frame_unpack
//   Drains bytes from the hsst2ad 8-bit async FIFO read port, hunts for the
//   EB 90 sync header, unpacks LEN big-endian 16-bit samples onto a
//   valid/ready stream and checks the trailing XOR checksum. Samples are
//   forwarded before the checksum is known; a bad checksum only raises
//   frame_err and bumps err_cnt.
// Ports
//   clk           in   FIFO read clock, single clock domain
//   tb_rst        in   async reset, active-high
//   fifo_rd_en    out  FIFO read strobe
//   fifo_rd_data  in   FIFO byte, valid the cycle after an accepted read
//   fifo_empty    in   FIFO rd_empty
//   s_data        out  sample {hi_byte, lo_byte}
//   s_valid       out  sample valid
//   s_last        out  last sample of a frame
//   s_ready       in   downstream accept
//   frame_ok      out  1-cycle pulse, checksum matched
//   frame_err     out  1-cycle pulse, checksum mismatch or LEN==0
//   ok_cnt        out  good frames, wraps
//   err_cnt       out  bad frames, saturates at all-ones

import hsst2ad_pkg::*;

module hsst2ad_frame_unpack #(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              tb_rst,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_empty,
  output logic [15:0]       s_data,
  output logic              s_valid,
  output logic              s_last,
  input  logic              s_ready,
  output logic              frame_ok,
  output logic              frame_err,
  output logic [CNT_W-1:0]  ok_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  state_t            state_q, state_d;
  logic [7:0]        rem_q, rem_d;
  logic [7:0]        xor_q, xor_d;
  logic [7:0]        hi_q, hi_d;
  logic              rdVld_q;
  logic              pendLo_q;
  logic              frameOk_q, frameOk_d;
  logic              frameErr_q, frameErr_d;
  logic [CNT_W-1:0]  okCnt_q, errCnt_q;
  logic              push;
  sample_t           pushData;
  sample_t           skidOut;
  logic [1:0]        occ;
  logic              credit;
  logic              rdEn;

  // Byte FSM: exactly one transition per landed byte, otherwise hold.
  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    xor_d         = xor_q;
    hi_d          = hi_q;
    push          = 1'b0;
    pushData.last = (rem_q == 8'd1);
    pushData.data = {hi_q, fifo_rd_data};
    frameOk_d     = 1'b0;
    frameErr_d    = 1'b0;
    if (rdVld_q) begin
      case (state_q)
        HUNT0: begin
          if (fifo_rd_data == SYNC0) state_d = HUNT1;
        end
        HUNT1: begin
          if (fifo_rd_data == SYNC1)      state_d = LEN;
          else if (fifo_rd_data != SYNC0) state_d = HUNT0;
        end
        LEN: begin
          if (fifo_rd_data == 8'd0) begin
            frameErr_d = 1'b1;
            state_d    = HUNT0;
          end else begin
            rem_d   = fifo_rd_data;
            xor_d   = 8'd0;
            state_d = HI;
          end
        end
        HI: begin
          hi_d    = fifo_rd_data;
          xor_d   = xor_q ^ fifo_rd_data;
          state_d = LO;
        end
        LO: begin
          push    = 1'b1;
          xor_d   = xor_q ^ fifo_rd_data;
          rem_d   = rem_q - 8'd1;
          state_d = (rem_q == 8'd1) ? CSUM : HI;
        end
        CSUM: begin
          if (fifo_rd_data == xor_q) frameOk_d  = 1'b1;
          else                       frameErr_d = 1'b1;
          state_d = HUNT0;
        end
        default: state_d = HUNT0;
      endcase
    end
  end

  // A read issued now lands while the FSM sits in state_d, so state_d tells
  // whether this read will complete a sample. Only those reads need a free
  // skid slot; at most one read is ever in flight, tracked by pendLo_q.
  assign credit     = (occ == 2'd0) || ((occ == 2'd1) && !pendLo_q);
  assign rdEn       = !tb_rst && !fifo_empty && ((state_d != LO) || credit);
  assign fifo_rd_en = rdEn;

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      state_q    <= HUNT0;
      rem_q      <= 8'd0;
      xor_q      <= 8'd0;
      hi_q       <= 8'd0;
      rdVld_q    <= 1'b0;
      pendLo_q   <= 1'b0;
      frameOk_q  <= 1'b0;
      frameErr_q <= 1'b0;
      okCnt_q    <= '0;
      errCnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      xor_q      <= xor_d;
      hi_q       <= hi_d;
      rdVld_q    <= rdEn;
      pendLo_q   <= rdEn && (state_d == LO);
      frameOk_q  <= frameOk_d;
      frameErr_q <= frameErr_d;
      if (frameOk_d) begin
        okCnt_q <= okCnt_q + CNT_W'(1);
      end
      if (frameErr_d && (errCnt_q != '1)) begin
        errCnt_q <= errCnt_q + CNT_W'(1);
      end
    end
  end

  hsst2ad_skid2 u_skid (
    .clk        (clk),
    .tb_rst     (tb_rst),
    .push_i     (push),
    .pushData_i (pushData),
    .outReady_i (s_ready),
    .outValid_o (s_valid),
    .outData_o  (skidOut),
    .occ_o      (occ)
  );

  assign s_data    = skidOut.data;
  assign s_last    = skidOut.last;
  assign frame_ok  = frameOk_q;
  assign frame_err = frameErr_q;
  assign ok_cnt    = okCnt_q;
  assign err_cnt   = errCnt_q;

endmodule

// File: tb/tb_hsst2ad_frame_unpack.sv
// tb_hsst2ad_frame_unpack
//   Self-checking bench for hsst2ad_frame_unpack. A 1-cycle-latency FIFO
//   model feeds both a default instance and a narrow-counter instance
//   (CNT_W=2) with identical inputs, so counter wrap and saturation can be
//   reached in a few frames.

module tb_hsst2ad_frame_unpack;

  localparam logic [7:0] TB_SYNC0 = 8'hEB;
  localparam logic [7:0] TB_SYNC1 = 8'h90;

  logic        clk = 1'b0;
  logic        tb_rst = 1'b1;
  logic [7:0]  fifo_rd_data = 8'h00;
  logic        fifo_empty = 1'b1;
  logic        s_ready = 1'b0;
  wire         fifo_rd_en;
  wire  [15:0] s_data;
  wire         s_valid, s_last, frame_ok, frame_err;
  wire  [15:0] ok_cnt, err_cnt;
  wire         rdEn2, sValid2, sLast2, fOk2, fErr2;
  wire  [15:0] sData2;
  wire  [1:0]  okCnt2, errCnt2;

  hsst2ad_frame_unpack dut (
    .clk(clk), .tb_rst(tb_rst), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_empty(fifo_empty), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .frame_ok(frame_ok), .frame_err(frame_err),
    .ok_cnt(ok_cnt), .err_cnt(err_cnt)
  );

  hsst2ad_frame_unpack #(.CNT_W(2)) dutNarrow (
    .clk(clk), .tb_rst(tb_rst), .fifo_rd_en(rdEn2), .fifo_rd_data(fifo_rd_data),
    .fifo_empty(fifo_empty), .s_data(sData2), .s_valid(sValid2), .s_last(sLast2),
    .s_ready(s_ready), .frame_ok(fOk2), .frame_err(fErr2),
    .ok_cnt(okCnt2), .err_cnt(errCnt2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0][7:0] bytes;
    int               nBytes;
    logic [3:0][16:0] samp;
    int               nSamp;
    int               expOk;
    int               expErr;
  } vec_t;

  vec_t        vecs[6];
  int          testsRun = 0;
  int          testsFailed = 0;
  logic [7:0]  fifoQ[$];
  logic [7:0]  streamQ[$];
  logic [16:0] expQ[$];
  logic [7:0]  pendByte;
  bit          pendVld = 0;
  int          okPulses, errPulses, emptyViol, bothViol, divergeViol;
  bit          scoreEn = 1;
  bit          gapEn = 0;
  int          readyMode = 0;
  int          cycleCnt = 0;
  bit          stallPrev = 0;
  logic [15:0] holdData;
  logic        holdLast;
  int          mOk, mErr;

  task automatic check(input string name, input longint act, input longint exp);
    testsRun++;
    if (act != exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, observe before the
  // next edge, and let the FIFO model accept a read if one was issued.
  task automatic stepCycle();
    logic [16:0] expSamp;
    fifo_rd_data = pendVld ? pendByte : 8'($urandom);
    pendVld      = 0;
    fifo_empty   = (fifoQ.size() == 0) || (gapEn && ($urandom_range(0, 2) == 0));
    case (readyMode)
      0:       s_ready = 1'b1;
      1:       s_ready = ((cycleCnt % 3) == 0);
      2:       s_ready = 1'b0;
      default: s_ready = 1'($urandom_range(0, 1));
    endcase
    #3;
    if (fifo_rd_en && fifo_empty) emptyViol++;
    if (frame_ok && frame_err) bothViol++;
    if ({rdEn2, sData2, sValid2, sLast2, fOk2, fErr2} !=
        {fifo_rd_en, s_data, s_valid, s_last, frame_ok, frame_err}) divergeViol++;
    okPulses  += int'(frame_ok);
    errPulses += int'(frame_err);
    if (stallPrev) begin
      check("holdWhileStalled", {s_valid, s_last, s_data}, {1'b1, holdLast, holdData});
    end
    stallPrev = s_valid && !s_ready;
    holdData  = s_data;
    holdLast  = s_last;
    if (s_valid && s_ready && scoreEn) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL extraSample: got {last,data}='h%0h, expected no sample", {s_last, s_data});
      end else begin
        expSamp = expQ.pop_front();
        check("sample", {s_last, s_data}, expSamp);
      end
    end
    if (fifo_rd_en && !fifo_empty) begin
      pendByte = fifoQ.pop_front();
      pendVld  = 1;
    end
    cycleCnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    tb_rst       = 1'b1;
    fifoQ.delete();
    expQ.delete();
    pendVld      = 0;
    fifo_empty   = 1'b0;
    s_ready      = 1'b1;
    fifo_rd_data = TB_SYNC0;
    #2;
    check("resetOutputs",
          {fifo_rd_en, s_valid, s_last, frame_ok, frame_err, s_data, ok_cnt, err_cnt, okCnt2, errCnt2}, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    tb_rst      = 1'b0;
    okPulses    = 0;
    errPulses   = 0;
    emptyViol   = 0;
    bothViol    = 0;
    divergeViol = 0;
    stallPrev   = 0;
  endtask

  task automatic runDrain(input string name, input int budget);
    int n = 0;
    while ((fifoQ.size() != 0 || pendVld || s_valid) && n < budget) begin
      stepCycle();
      n++;
    end
    check({name, " drainInBudget"}, longint'(n < budget), 1);
    repeat (3) stepCycle();
  endtask

  task automatic checkOutput(input string name, input int expOk, input int expErr);
    check({name, " leftoverSamples"}, expQ.size(), 0);
    check({name, " okPulses"}, okPulses, expOk);
    check({name, " errPulses"}, errPulses, expErr);
    check({name, " ok_cnt"}, ok_cnt, expOk);
    check({name, " err_cnt"}, err_cnt, expErr);
    check({name, " okCntWrap"}, okCnt2, expOk % 4);
    check({name, " errCntSat"}, errCnt2, (expErr > 3) ? 3 : expErr);
    check({name, " rdEnWhileEmpty"}, emptyViol, 0);
    check({name, " okAndErrTogether"}, bothViol, 0);
    check({name, " narrowDiverge"}, divergeViol, 0);
  endtask

  // Reference: scan the byte stream for the first adjacent EB 90, take the
  // frame that follows by length, and compare the checksum byte with the
  // XOR of the payload.
  function automatic void modelParse();
    int         p = 0;
    int         n = streamQ.size();
    int         len;
    logic [7:0] x, hi, lo;
    mOk  = 0;
    mErr = 0;
    while (p + 2 < n) begin
      if (streamQ[p] == TB_SYNC0 && streamQ[p+1] == TB_SYNC1) begin
        len = int'(streamQ[p+2]);
        if (len == 0) begin
          mErr++;
          p += 3;
        end else begin
          x = 8'h00;
          for (int k = 0; k < len; k++) begin
            hi = streamQ[p+3+2*k];
            lo = streamQ[p+4+2*k];
            expQ.push_back({(k == len - 1), hi, lo});
            x = x ^ hi ^ lo;
          end
          if (streamQ[p+3+2*len] == x) mOk++;
          else                         mErr++;
          p += 4 + 2 * len;
        end
      end else begin
        p++;
      end
    end
  endfunction

  function automatic logic [7:0] junkByte();
    logic [7:0] b;
    do b = 8'($urandom); while (b == TB_SYNC0);
    return b;
  endfunction

  function automatic void addFrame(input int len, input bit good);
    logic [7:0] x = 8'h00;
    logic [7:0] b;
    streamQ.push_back(TB_SYNC0);
    streamQ.push_back(TB_SYNC1);
    streamQ.push_back(8'(len));
    if (len == 0) return;
    for (int k = 0; k < 2 * len; k++) begin
      b = 8'($urandom);
      streamQ.push_back(b);
      x ^= b;
    end
    streamQ.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
  endfunction

  initial begin
    vecs[0] = '{128'hEB90021234567808, 8, {17'h01234, 17'h15678, 34'h0}, 2, 1, 0};
    vecs[1] = '{128'hEB90021234567800, 8, {17'h01234, 17'h15678, 34'h0}, 2, 0, 1};
    vecs[2] = '{128'h00EBEB9001ABCD66, 8, {17'h1ABCD, 51'h0}, 1, 1, 0};
    vecs[3] = '{128'hEB9000EB9001ABCD66, 9, {17'h1ABCD, 51'h0}, 1, 1, 1};
    vecs[4] = '{128'hEB9002123456782A, 8, {17'h01234, 17'h15678, 34'h0}, 2, 0, 1};
    vecs[5] = '{128'h90EB12EB9001000101, 9, {17'h10001, 51'h0}, 1, 1, 0};

    @(posedge clk);
    #1;

    // Table vectors: first with a steady FIFO and ready, then with gaps and
    // random backpressure.
    for (int pass = 0; pass < 2; pass++) begin
      gapEn     = (pass == 1);
      readyMode = (pass == 1) ? 3 : 0;
      for (int v = 0; v < 6; v++) begin
        applyReset();
        for (int k = 0; k < vecs[v].nBytes; k++) fifoQ.push_back(vecs[v].bytes[vecs[v].nBytes - 1 - k]);
        for (int k = 0; k < vecs[v].nSamp; k++) expQ.push_back(vecs[v].samp[3 - k]);
        runDrain($sformatf("vec%0d.%0d", v, pass), 200);
        checkOutput($sformatf("vec%0d.%0d", v, pass), vecs[v].expOk, vecs[v].expErr);
      end
    end

    // Long stall: two samples fill the skid, the next hi byte is still
    // drained, then reads stop until the consumer accepts.
    gapEn     = 0;
    readyMode = 2;
    applyReset();
    streamQ = '{8'hEB, 8'h90, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
    foreach (streamQ[i]) fifoQ.push_back(streamQ[i]);
    expQ = '{17'h01122, 17'h03344, 17'h05566, 17'h17788};
    repeat (30) stepCycle();
    check("stall fifoRemaining", fifoQ.size(), 4);
    check("stall headSample", {s_valid, s_last, s_data}, {1'b1, 1'b0, 16'h1122});
    readyMode = 0;
    runDrain("stall", 200);
    checkOutput("stall", 1, 0);

    // 255-sample frame plus mixed short frames, ready 1-in-3, random gaps.
    applyReset();
    readyMode = 1;
    gapEn     = 1;
    streamQ.delete();
    repeat (3) streamQ.push_back(junkByte());
    addFrame(255, 1);
    foreach (streamQ[i]) begin end
    begin
      int kinds[10] = '{1, 0, 1, 2, 0, 1, 0, 1, 0, 1};
      for (int f = 0; f < 10; f++) begin
        repeat ($urandom_range(0, 2)) streamQ.push_back(junkByte());
        if (kinds[f] == 2) addFrame(0, 0);
        else               addFrame($urandom_range(1, 6), kinds[f] == 1);
      end
    end
    foreach (streamQ[i]) fifoQ.push_back(streamQ[i]);
    modelParse();
    check("random expectedSampleCount", expQ.size() >= 255, 1);
    runDrain("random", 8000);
    checkOutput("random", mOk, mErr);

    // Reset in the middle of a payload, then a fresh frame.
    applyReset();
    readyMode = 0;
    gapEn     = 0;
    scoreEn   = 0;
    streamQ = '{8'hEB, 8'h90, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h08};
    foreach (streamQ[i]) fifoQ.push_back(streamQ[i]);
    repeat (9) stepCycle();
    applyReset();
    scoreEn = 1;
    streamQ = '{8'hEB, 8'h90, 8'h01, 8'hAB, 8'hCD, 8'h66};
    foreach (streamQ[i]) fifoQ.push_back(streamQ[i]);
    expQ.push_back(17'h1ABCD);
    runDrain("afterReset", 200);
    checkOutput("afterReset", 1, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
